// File: rtl/instruction_loader.sv
// Boot loader: assembles little-endian 32-bit words from a UART byte stream into the
// instruction ROM, then releases the core. Optional trailing XOR checksum: LOADER_CHECKSUM_EN.
module instruction_loader #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              rom_wren,
    output logic [ADDR_W-1:0] rom_address,
    output logic [31:0]       rom_write_data,
    output logic              cpu_run,
    output logic              load_error,
    output logic [ADDR_W-2:0] words_loaded
);
    localparam int          WCNT_W   = ADDR_W - 1;
    localparam logic [31:0] CAPACITY = 32'(1) << (ADDR_W - 2);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {HEADER, DATA, CSUM, DONE, ERROR} state_t;
    localparam state_t IMG_END = CSUM;
`else
    typedef enum logic [2:0] {HEADER, DATA, DONE, ERROR} state_t;
    localparam state_t IMG_END = DONE;
`endif

    state_t              state_q, state_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [31:0]         shift_q, shift_d;
    logic [WCNT_W-1:0]   total_q, total_d;
    logic [WCNT_W-1:0]   words_q, words_d;
    logic                wren_q, wren_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          xor_q, xor_d;
`endif

    logic        hs;
    logic [31:0] word_in;

    assign rx_ready = (state_q == HEADER) || (state_q == DATA)
`ifdef LOADER_CHECKSUM_EN
                      || (state_q == CSUM)
`endif
                      ;
    assign hs      = rx_valid && rx_ready;
    // First byte received ends up in bits [7:0] after four shifts.
    assign word_in = {rx_data, shift_q[31:8]};

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        total_d    = total_q;
        words_d    = words_q;
        wren_d     = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        xor_d      = xor_q;
        if (hs && (state_q == HEADER || state_q == DATA)) xor_d = xor_q ^ rx_data;
`endif
        case (state_q)
            HEADER: if (hs) begin
                byte_cnt_d = byte_cnt_q + 2'd1;
                shift_d    = word_in;
                if (byte_cnt_q == 2'd3) begin
                    total_d = word_in[WCNT_W-1:0];
                    if (word_in > CAPACITY)  state_d = ERROR;
                    else if (word_in == '0)  state_d = IMG_END;
                    else                     state_d = DATA;
                end
            end
            DATA: if (hs) begin
                byte_cnt_d = byte_cnt_q + 2'd1;
                shift_d    = word_in;
                if (byte_cnt_q == 2'd3) begin
                    wren_d  = 1'b1;
                    wdata_d = word_in;
                    addr_d  = {words_q[ADDR_W-3:0], 2'b00};
                    words_d = words_q + 1'b1;
                    if (words_d == total_q) state_d = IMG_END;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: if (hs) state_d = (rx_data == xor_q) ? DONE : ERROR;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= HEADER;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            total_q    <= '0;
            words_q    <= '0;
            wren_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            total_q    <= total_d;
            words_q    <= words_d;
            wren_q     <= wren_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= xor_d;
`endif
        end
    end

    assign rom_wren       = wren_q;
    assign rom_address    = addr_q;
    assign rom_write_data = wdata_q;
    assign words_loaded   = words_q;
    // Hold the core back through the final write pulse so the ROM is complete first.
    assign cpu_run        = (state_q == DONE) && !wren_q;
    assign load_error     = (state_q == ERROR);

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized/directed bench for instruction_loader; expected writes and timing come from
// a byte-stream parser model, checked with immediate assertions.
module tb_instruction_loader;
    localparam int ADDR_W = 12;
    localparam longint CAP = 64'd1 << (ADDR_W - 2);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready, rom_wren, cpu_run, load_error;
    logic [ADDR_W-1:0] rom_address;
    logic [31:0]       rom_write_data;
    logic [ADDR_W-2:0] words_loaded;

    instruction_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .rom_wren(rom_wren), .rom_address(rom_address),
        .rom_write_data(rom_write_data), .cpu_run(cpu_run), .load_error(load_error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;
    int hs_cyc[$];
    int wr_cyc[$];
    longint wr_addr[$];
    longint wr_data[$];
    int run_cyc = -1;
    int err_cyc = -1;

    // Observer on the falling edge: a handshake seen here commits at the next rising edge.
    always @(negedge clk) begin
        cyc++;
        if (rom_wren) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(longint'(rom_address));
            wr_data.push_back(longint'(rom_write_data));
        end
        if (cpu_run && run_cyc < 0) run_cyc = cyc;
        if (load_error && err_cyc < 0) err_cyc = cyc;
        if (rx_valid && rx_ready) hs_cyc.push_back(cyc);
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -100;
    endfunction

    function automatic logic [7:0] xsum(input logic [7:0] q[$]);
        logic [7:0] x = 8'h00;
        foreach (q[i]) x ^= q[i];
        return x;
    endfunction

    task automatic clear_log();
        hs_cyc.delete(); wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        run_cyc = -1; err_cyc = -1;
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        clear_log();
    endtask

    task automatic send(input logic [7:0] b[$], input int max_gap);
        foreach (b[i]) begin
            repeat ($urandom_range(max_gap, 0)) begin
                rx_valid = 1'b0;
                @(posedge clk); #1;
            end
            rx_valid = 1'b1;
            rx_data  = b[i];
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
    endtask

    // Reference: parse the stream as header + N words (+ checksum), derive expected outcome.
    task automatic run_image(input string tag, input logic [7:0] b[$], input int max_gap);
        longint n;
        int     img_len, n_wr;
        bit     err;
        do_reset();
        send(b, max_gap);
        repeat (4) @(posedge clk);
        #1;
        n = longint'({b[3], b[2], b[1], b[0]});
        if (n > CAP) begin
            err = 1'b1; img_len = 4; n_wr = 0;
        end else begin
            err = 1'b0; img_len = 4 + 4 * int'(n); n_wr = int'(n);
`ifdef LOADER_CHECKSUM_EN
            err = (b[img_len] != xsum(b[0:img_len-1]));
            img_len++;
`endif
        end
        chk({tag, " handshakes"}, hs_cyc.size(), img_len);
        chk({tag, " wren_count"}, wr_cyc.size(), n_wr);
        for (int i = 0; i < n_wr && i < wr_cyc.size(); i++) begin
            chk($sformatf("%s w%0d addr", tag, i), wr_addr[i], 4 * i);
            chk($sformatf("%s w%0d data", tag, i), wr_data[i],
                longint'({b[4*i+7], b[4*i+6], b[4*i+5], b[4*i+4]}));
            chk($sformatf("%s w%0d cycle", tag, i), wr_cyc[i], qget(hs_cyc, 4 * i + 7) + 1);
        end
        chk({tag, " words_loaded"}, longint'(words_loaded), n_wr);
        chk({tag, " load_error"}, longint'(load_error), longint'(err));
        chk({tag, " cpu_run"}, longint'(cpu_run), longint'(!err));
        chk({tag, " rx_ready"}, longint'(rx_ready), 0);
        if (err) begin
            chk({tag, " err_cycle"}, err_cyc, qget(hs_cyc, img_len - 1) + 1);
        end else begin
`ifdef LOADER_CHECKSUM_EN
            chk({tag, " run_cycle"}, run_cyc, qget(hs_cyc, img_len - 1) + 1);
`else
            chk({tag, " run_cycle"}, run_cyc,
                qget(hs_cyc, img_len - 1) + ((n == 0) ? 1 : 2));
`endif
        end
    endtask

    logic [7:0] img_a[$];
    logic [7:0] q[$];
    int         nw;

    initial begin
        img_a = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                  8'h93, 8'h05, 8'h20, 8'h00};

        // Reset values, sampled while reset is still held.
        #2;
        chk("rst rx_ready", longint'(rx_ready), 1);
        chk("rst rom_wren", longint'(rom_wren), 0);
        chk("rst rom_address", longint'(rom_address), 0);
        chk("rst rom_write_data", longint'(rom_write_data), 0);
        chk("rst cpu_run", longint'(cpu_run), 0);
        chk("rst load_error", longint'(load_error), 0);
        chk("rst words_loaded", longint'(words_loaded), 0);

        q = img_a;
`ifdef LOADER_CHECKSUM_EN
        q.push_back(8'hB2);
`endif
        q.push_back(8'h55);  // trailing byte must be dropped
        run_image("A b2b", q, 0);
        chk("A data0 const", (wr_data.size() > 0) ? wr_data[0] : -1, 64'h00100513);
        chk("A data1 const", (wr_data.size() > 1) ? wr_data[1] : -1, 64'h00200593);
        run_image("A gaps", q, 3);

        for (int t = 0; t < 3; t++) begin
            nw = $urandom_range(8, 1);
            q = '{};
            q.push_back(8'(nw));
            q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'h00);
            for (int k = 0; k < 4 * nw; k++) q.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
            q.push_back(xsum(q));
`endif
            q.push_back(8'($urandom)); q.push_back(8'($urandom));
            run_image($sformatf("rnd%0d", t), q, t);
        end

        q = '{8'h00, 8'h00, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        q.push_back(8'h00);
`endif
        q.push_back(8'hAA);
        run_image("N0", q, 0);

        q = '{8'h01, 8'h04, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_image("N1025", q, 1);

        // Exactly-capacity header is legal.
        do_reset();
        q = '{8'h00, 8'h04, 8'h00, 8'h00};
        send(q, 0);
        #2;
        chk("N1024 load_error", longint'(load_error), 0);
        chk("N1024 rx_ready", longint'(rx_ready), 1);
        chk("N1024 cpu_run", longint'(cpu_run), 0);

`ifdef LOADER_CHECKSUM_EN
        q = img_a;
        q.push_back(8'hB3);
        run_image("A badcsum", q, 0);
`endif

        // Reset mid-load, then replay.
        do_reset();
        q = img_a[0:5];
        send(q, 0);
        reset = 1'b1;
        #1;
        chk("midrst rx_ready", longint'(rx_ready), 1);
        chk("midrst words_loaded", longint'(words_loaded), 0);
        chk("midrst rom_wren", longint'(rom_wren), 0);
        @(posedge clk); #1;
        q = img_a;
`ifdef LOADER_CHECKSUM_EN
        q.push_back(8'hB2);
`endif
        run_image("A replay", q, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/instruction_loader.md
# instruction_loader

Boot-time block that sits directly upstream of the CPU core. It receives a byte stream from the UART receiver and assembles little-endian 32-bit instruction words. Each word is written into the instruction ROM write port. Once the image is complete, it releases the core via `cpu_run`; the CPU's `reset_n` is driven from `cpu_run`.

## Interface
Parameters:
- `ADDR_W`, default 12: ROM byte-address width. Capacity is `2^(ADDR_W-2)` words.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `rx_valid` in 1: `rx_data` holds a byte.
- `rx_data` in 8: received byte.
- `rx_ready` out 1: loader accepts a byte this cycle.
- `rom_wren` out 1: ROM write strobe, one-cycle pulse per word.
- `rom_address` out ADDR_W: ROM byte address, always a multiple of 4.
- `rom_write_data` out 32: instruction word.
- `cpu_run` out 1: image complete; CPU may leave reset.
- `load_error` out 1: sticky error flag.
- `words_loaded` out ADDR_W-1: number of words written so far.

## Operation
- A handshake occurs on a rising edge where `rx_valid && rx_ready`. Bytes arriving while `rx_ready=0` are dropped; the loader never stalls the sender mid-image.
- `rx_ready` is combinational from state: 1 in HEADER, DATA and CSUM; 0 in DONE and ERROR.
- States: HEADER → DATA → (CSUM) → DONE, with ERROR reachable as noted.
- **HEADER:** collects 4 bytes as a 32-bit word count N, first byte → bits [7:0].
  - N > `2^(ADDR_W-2)` → ERROR.
  - N = 0 → DONE, or CSUM if the checksum feature is compiled in.
  - Otherwise → DATA.
- **DATA:** collects 4 bytes per word, little-endian, using a 2-bit byte counter.
  - On the 4th byte, the assembled word is registered to `rom_write_data`, `rom_address = words_loaded*4`, `rom_wren` pulses, and `words_loaded` increments.
  - After word N the state moves to DONE, or CSUM if compiled in.
- **DONE:** `cpu_run=1`. Holds until reset.
- **ERROR:** `load_error=1`, `cpu_run=0`. Holds until reset.
- The ROM is never written outside DATA. Partially assembled words are never written.

## Timing
- Reset values: state HEADER; `rx_ready=1`; `rom_wren=0`; `rom_address=0`; `rom_write_data=0`; `cpu_run=0`; `load_error=0`; `words_loaded=0`; byte counter 0.
- One byte per cycle is sustained with no bubbles. Gaps in `rx_valid` are tolerated anywhere in the stream.
- `rom_wren` is high exactly in the cycle after the handshake of a word's 4th byte. Address and data are stable during that cycle.
- Back-to-back words yield `rom_wren` pulses 4 cycles apart at the earliest.
- `cpu_run` rises exactly one cycle after the final `rom_wren` pulse, so the ROM write completes before the core runs.
  - N=0: `cpu_run` rises one cycle after the 4th header byte.
  - With checksum: `cpu_run` rises one cycle after the checksum byte handshake.
- ERROR is entered, and `load_error` asserted, one cycle after the offending handshake.
- Reset asserted mid-load: all outputs return to reset values asynchronously. ROM contents already written are left untouched, and the next byte is treated as header byte 0.

## Configuration
- Macro: `LOADER_CHECKSUM_EN`.
- Defined:
  - A running XOR of every accepted header and data byte is kept.
  - After the last word (or after the header when N=0), CSUM accepts one byte.
  - If the byte equals the running XOR → DONE; otherwise → ERROR.
- Undefined: no CSUM state and no XOR register. The loader goes directly to DONE after the last word, and any byte following the image is dropped (`rx_ready=0`).

## Test plan
- Stream `02 00 00 00 13 05 10 00 93 05 20 00`, back-to-back:
  - `rom_wren` pulses at address 0x000 with data 0x00100513, then at address 0x004 with data 0x00200593.
  - `words_loaded=2`.
  - `cpu_run` rises one cycle after the 2nd pulse.
- Same stream with random 0–3 cycle gaps in `rx_valid`: identical writes and final state; no extra `rom_wren` pulses.
- Header `00 00 00 00`: no `rom_wren` at all; `cpu_run=1` one cycle after the 4th byte (checksum undefined).
- With `ADDR_W=12`, header `01 04 00 00` (N=1025): `load_error=1` and `cpu_run=0`; subsequent bytes see `rx_ready=0` and produce no writes.
- With `LOADER_CHECKSUM_EN`, the first stream plus checksum byte:
  - `B2` → `cpu_run=1`.
  - `B3` → `load_error=1`, `cpu_run=0`.
- Assert `reset` after 6 bytes of the first stream, then replay the full stream: the 1st word is written exactly once after the replay, and the final outputs match the first scenario.
